// File: rtl/vga_scan_reader.sv
// vga_scan_reader: 640x480@60 raster scan engine for the frame-buffer read path.
// Generates pixel_x/pixel_y addresses, captures the RGB332 pixel returned by a
// synchronous RAM RD_LAT clocks later, and drives hsync/vsync/RGB aligned with it.
// Optional feature macro: VGA_SCAN_BORDER_EN (forces white on the visible frame edge).
module vga_scan_reader #(
  parameter int PIX_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int RD_LAT   = 1    // read latency of the pixel source; must be >= 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pixel_rgb,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [1:0] vga_b,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
`ifdef VGA_SCAN_BORDER_EN
  localparam logic [9:0] H_EDGE   = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_EDGE   = 10'(V_ACTIVE - 1);
`endif

  // One stage of the alignment delay line: raw flags for a single clk.
  typedef struct packed {
    logic hs;
    logic vs;
    logic on;
`ifdef VGA_SCAN_BORDER_EN
    logic on_edge;
`endif
  } align_t;

`ifdef VGA_SCAN_BORDER_EN
  localparam align_t STAGE_RESET = '{hs: 1'b1, vs: 1'b1, on: 1'b0, on_edge: 1'b0};
`else
  localparam align_t STAGE_RESET = '{hs: 1'b1, vs: 1'b1, on: 1'b0};
`endif

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic             tick;
  align_t           raw;
  align_t           dly [RD_LAT];

  assign tick     = (div_cnt == DIV_LAST);
  assign pixel_x  = h_cnt;
  assign pixel_y  = v_cnt;
  assign video_on = (h_cnt < H_VIS) && (v_cnt < V_VIS);

  // Pixel-rate divider, raster counters and the undelayed frame_start pulse.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      div_cnt     <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          if (v_cnt == V_LAST) begin
            v_cnt       <= '0;
            frame_start <= 1'b1;
          end else begin
            v_cnt <= v_cnt + 10'd1;
          end
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  // Raw active-low syncs and active-area flag decoded from the counters.
  // NOTE: every field gets a default first so no path can infer a latch.
  always_comb begin
    raw    = STAGE_RESET;
    raw.hs = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    raw.vs = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
    raw.on = video_on;
`ifdef VGA_SCAN_BORDER_EN
    raw.on_edge = (h_cnt == 10'd0) || (h_cnt == H_EDGE) ||
                  (v_cnt == 10'd0) || (v_cnt == V_EDGE);
`endif
  end

  // RD_LAT-deep delay line so the flags meet the RAM data at the output stage.
  // NOTE: this small register array is reset on purpose: its contents reach the
  // sync pins directly, so stale stages would glitch hsync/vsync after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) dly[i] <= STAGE_RESET;
    end else begin
      dly[0] <= raw;
      for (int i = 1; i < RD_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  // Output stage: register delayed flags together with the returned pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync                 <= 1'b1;
      vsync                 <= 1'b1;
      {vga_r, vga_g, vga_b} <= 8'h00;
    end else begin
      hsync <= dly[RD_LAT-1].hs;
      vsync <= dly[RD_LAT-1].vs;
      if (dly[RD_LAT-1].on) begin
`ifdef VGA_SCAN_BORDER_EN
        {vga_r, vga_g, vga_b} <= dly[RD_LAT-1].on_edge ? 8'hFF : pixel_rgb;
`else
        {vga_r, vga_g, vga_b} <= pixel_rgb;
`endif
      end else begin
        {vga_r, vga_g, vga_b} <= 8'h00;
      end
    end
  end

endmodule
